hex_display_ctrl: RTL and testbench

- Parametrised multi-digit hexadecimal 7-segment display controller. Replaces per-digit hard-wired decoders at board top level.
- Accepts a packed nibble word and a control word from the CPU/bus side via write strobes.
- Adds enable, leading-zero suppression, per-digit blinking and a time-multiplexed scan output alongside the parallel per-digit outputs.
- Sits between the soft-CPU output port and the board HEX pins.

---
 rtl/hex_display_pkg.sv | 30 +++
 rtl/hex_seg_decoder.sv | 23 ++
 rtl/hex_display_ctrl.sv | 154 +++++++++++++++
 tb/tb_hex_display_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// ---------------------------------------------------------------------------
// hex_display_pkg
// Shared definitions for the hex display controller:
//   - GLYPHS      : active-high 7-segment glyphs for nibbles 0..F (gfedcba)
//   - seg_off()   : the "all segments dark" pattern for a given polarity
//   - CTRL_*      : bit positions inside the control word
//   - cnt_width() : counter width for a divisor (never narrower than 1 bit)
// ---------------------------------------------------------------------------
package hex_display_pkg;

   localparam int CTRL_EN        = 0;
   localparam int CTRL_LZ        = 1;
   localparam int CTRL_BLINK_LSB = 2;

   localparam logic [6:0] GLYPHS [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Dark pattern: all ones when segments light on a low level, else zeros.
   function automatic logic [6:0] seg_off(input bit active_low);
      return active_low ? 7'h7F : 7'h00;
   endfunction

   // A divisor of 1 still needs a one-bit counter so the logic stays legal.
   function automatic int cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// ---------------------------------------------------------------------------
// hex_seg_decoder
// Combinational nibble to 7-segment glyph decoder.
// Parameters:
//   ACTIVE_LOW : 1 = segment lit on a 0 bit, output is the inverted glyph
// Ports:
//   nibble : input  [3:0] hex value to show
//   seg    : output [6:0] glyph, bit order gfedcba (bit0 = a)
// ---------------------------------------------------------------------------
module hex_seg_decoder
#(
   parameter bit ACTIVE_LOW = 1'b1
)
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   import hex_display_pkg::*;

   // Table lookup, then flip the polarity for boards that light on a low level.
   assign seg = ACTIVE_LOW ? ~GLYPHS[nibble] : GLYPHS[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl
// Multi-digit hex 7-segment controller with enable, leading-zero
// suppression, per-digit blinking and a time-multiplexed scan output.
// Parameters:
//   DIGITS, BLINK_DIV, SCAN_DIV, SEG_ACTIVE_LOW, SEL_ACTIVE_LOW
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   wr_data_en    : load wr_data (packed nibbles, [3:0] = rightmost digit)
//   wr_ctrl_en    : load wr_ctrl ([0] enable, [1] lz_suppress, [DIGITS+1:2] blink)
//   seg           : registered parallel segments, [6:0] = digit 0
//   seg_mux       : registered segments of the scanned digit
//   dig_sel       : registered one-hot scanned-digit select
//   rd_data       : data register readback
// ---------------------------------------------------------------------------
module hex_display_ctrl
#(
   parameter int DIGITS         = 6,
   parameter int BLINK_DIV      = 25000000,
   parameter int SCAN_DIV       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit SEL_ACTIVE_LOW = 1'b1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_data_en,
   input  logic [4*DIGITS-1:0]   wr_data,
   input  logic                  wr_ctrl_en,
   input  logic [DIGITS+1:0]     wr_ctrl,
   output logic [7*DIGITS-1:0]   seg,
   output logic [6:0]            seg_mux,
   output logic [DIGITS-1:0]     dig_sel,
   output logic [4*DIGITS-1:0]   rd_data
);
   import hex_display_pkg::*;

   localparam int BW = cnt_width(BLINK_DIV);
   localparam int SW = cnt_width(SCAN_DIV);
   localparam int IW = cnt_width(DIGITS);

   localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [SW-1:0]     SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [6:0]        SEG_OFF    = seg_off(SEG_ACTIVE_LOW);
   localparam logic [DIGITS-1:0] SEL_NONE   = {DIGITS{SEL_ACTIVE_LOW}};

   logic [4*DIGITS-1:0] data_q;
   logic [DIGITS+1:0]   ctrl_q;
   logic [BW-1:0]       blink_cnt;
   logic                blink_phase;
   logic [SW-1:0]       scan_cnt;
   logic [IW-1:0]       scan_idx;

   logic                enable;
   logic                lz_suppress;
   logic [DIGITS-1:0]   blink_mask;

   logic [6:0]          glyph     [DIGITS];
   logic [6:0]          digit_seg [DIGITS];
   logic [7*DIGITS-1:0] seg_next;
   logic                all_zero;
   logic [DIGITS-1:0]   sel_onehot;

   assign enable      = ctrl_q[CTRL_EN];
   assign lz_suppress = ctrl_q[CTRL_LZ];
   assign blink_mask  = ctrl_q[DIGITS+1:CTRL_BLINK_LSB];
   assign rd_data     = data_q;

   // One glyph decoder per digit, fed straight from the data register.
   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      hex_seg_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
         .nibble (data_q[4*g +: 4]),
         .seg    (glyph[g])
      );
   end

   // Bus-side registers. Both strobes may load in the same cycle; reset wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         ctrl_q <= '0;
      end else begin
         if (wr_data_en) data_q <= wr_data;
         if (wr_ctrl_en) ctrl_q <= wr_ctrl;
      end
   end

   // Blink timer. A control write restarts the blink period in the visible
   // phase, so software always gets the same alignment after reprogramming.
   always_ff @(posedge clk) begin
      if (rst || wr_ctrl_en || !enable) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   // Scan timer. Held at zero while disabled, so re-enabling always starts
   // the scan from the rightmost digit.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Blanking. Walking from the leftmost digit down, all_zero tells whether
   // this nibble and everything to its left is zero; digit 0 is exempt so a
   // zero value still shows a single "0".
   always_comb begin
      all_zero = 1'b1;
      seg_next = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         all_zero = all_zero & (data_q[4*i +: 4] == 4'h0);
         if (!enable || (lz_suppress && (i > 0) && all_zero) ||
             (blink_mask[i] && blink_phase))
            digit_seg[i] = SEG_OFF;
         else
            digit_seg[i] = glyph[i];
         seg_next[7*i +: 7] = digit_seg[i];
      end
   end

   // Active-high one-hot of the scanned digit; empty while disabled.
   always_comb begin
      sel_onehot = '0;
      if (enable) sel_onehot = DIGITS'(1) << scan_idx;
   end

   // Output registers: one cycle behind the data/control registers, with the
   // mux slice and digit select taken from the same scan index.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg     <= {DIGITS{SEG_OFF}};
         seg_mux <= SEG_OFF;
         dig_sel <= SEL_NONE;
      end else begin
         seg     <= seg_next;
         seg_mux <= enable ? digit_seg[scan_idx] : SEG_OFF;
         dig_sel <= sel_onehot ^ SEL_NONE;
      end
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_display_ctrl
// Self-checking bench for hex_display_ctrl (DIGITS=6, BLINK_DIV=4,
// SCAN_DIV=2, active-low segments and selects). A reference model derives
// blink phase and scan position from elapsed-cycle counts with plain
// division, and every cycle's outputs are compared against it, alongside a
// few hand-computed glyph patterns.
// ---------------------------------------------------------------------------
module tb_hex_display_ctrl;

   localparam int DIGITS    = 6;
   localparam int BLINK_DIV = 4;
   localparam int SCAN_DIV  = 2;

   localparam logic [6:0] GLYPH_TB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_data_en;
   logic [23:0] wr_data;
   logic        wr_ctrl_en;
   logic [7:0]  wr_ctrl;
   logic [41:0] seg;
   logic [6:0]  seg_mux;
   logic [5:0]  dig_sel;
   logic [23:0] rd_data;

   // Reference model state: register contents plus elapsed-cycle counts.
   logic [23:0] mData;
   logic [7:0]  mCtrl;
   int          blinkTicks;
   int          scanTicks;
   logic [41:0] expSeg;
   logic [6:0]  expMux;
   logic [5:0]  expSel;

   int          checks = 0;
   int          errors = 0;

   logic [41:0] allOff = {6{7'h7F}};
   logic [5:0]  scanExp [14] = '{6'h3E, 6'h3E, 6'h3D, 6'h3D, 6'h3B, 6'h3B,
                                 6'h37, 6'h37, 6'h2F, 6'h2F, 6'h1F, 6'h1F,
                                 6'h3E, 6'h3E};

   hex_display_ctrl #(
      .DIGITS         (DIGITS),
      .BLINK_DIV      (BLINK_DIV),
      .SCAN_DIV       (SCAN_DIV),
      .SEG_ACTIVE_LOW (1'b1),
      .SEL_ACTIVE_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_data_en (wr_data_en),
      .wr_data    (wr_data),
      .wr_ctrl_en (wr_ctrl_en),
      .wr_ctrl    (wr_ctrl),
      .seg        (seg),
      .seg_mux    (seg_mux),
      .dig_sel    (dig_sel),
      .rd_data    (rd_data)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // What digit i should show, from the display rules alone.
   function automatic logic [6:0] modelDigit(input int i, input logic [23:0] d,
                                             input logic [7:0] c, input int bt);
      logic [3:0] nib;
      bit         blank;
      nib   = d[4*i +: 4];
      blank = 1'b0;
      if (!c[0]) blank = 1'b1;
      if (c[1] && i > 0 && (d >> (4*i)) == 24'h0) blank = 1'b1;
      if (c[2+i] && ((bt / BLINK_DIV) % 2) == 1) blank = 1'b1;
      return blank ? 7'h7F : ~GLYPH_TB[nib];
   endfunction

   // Drive one cycle of inputs, advance the model across the edge, and
   // compare all outputs shortly after the edge.
   task automatic applyStimulus(input logic r, input logic de, input logic [23:0] d,
                                input logic ce, input logic [7:0] c);
      int idx;
      rst        = r;
      wr_data_en = de;
      wr_data    = d;
      wr_ctrl_en = ce;
      wr_ctrl    = c;
      @(posedge clk);
      if (r) begin
         expSeg     = {6{7'h7F}};
         expMux     = 7'h7F;
         expSel     = 6'h3F;
         mData      = '0;
         mCtrl      = '0;
         blinkTicks = 0;
         scanTicks  = 0;
      end else begin
         idx = (scanTicks / SCAN_DIV) % DIGITS;
         for (int i = 0; i < DIGITS; i++)
            expSeg[7*i +: 7] = modelDigit(i, mData, mCtrl, blinkTicks);
         expMux = mCtrl[0] ? modelDigit(idx, mData, mCtrl, blinkTicks) : 7'h7F;
         expSel = mCtrl[0] ? ~(6'd1 << idx) : 6'h3F;
         if (ce)            blinkTicks = 0;
         else if (mCtrl[0]) blinkTicks++;
         else               blinkTicks = 0;
         if (mCtrl[0]) scanTicks++;
         else          scanTicks = 0;
         if (de) mData = d;
         if (ce) mCtrl = c;
      end
      #1;
      checkOutput("seg", seg, expSeg);
      checkOutput("seg_mux", seg_mux, expMux);
      checkOutput("dig_sel", dig_sel, expSel);
      checkOutput("rd_data", rd_data, mData);
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 8'h0);
   endtask

   initial begin
      logic [7:0]  rc;
      logic [23:0] rdat;
      logic        rr, rde, rce;

      // Reset then idle: display dark and deselected.
      applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 8'h0);
      applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 8'h0);
      for (int n = 0; n < 10; n++) idle();
      checkOutput("reset_seg", seg, allOff);
      checkOutput("reset_dig_sel", dig_sel, 6'h3F);
      checkOutput("reset_rd_data", rd_data, 24'h0);

      // Simultaneous data + ctrl write: both load, glyphs one edge later.
      applyStimulus(1'b0, 1'b1, 24'h00A5C3, 1'b1, 8'h01);
      checkOutput("simul_rd_data", rd_data, 24'h00A5C3);
      idle();
      checkOutput("glyphs_A5C3", seg, {7'h40, 7'h40, 7'h08, 7'h12, 7'h46, 7'h30});

      // Leading-zero suppression.
      applyStimulus(1'b0, 1'b1, 24'h000000, 1'b1, 8'h03);
      idle();
      checkOutput("lz_zero", seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      applyStimulus(1'b0, 1'b1, 24'h000010, 1'b0, 8'h00);
      idle();
      checkOutput("lz_ten", seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40});

      // Blink digit 0: 4 visible, then blank; a ctrl rewrite mid-blank
      // makes it visible on the following cycle.
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 8'h05);
      for (int n = 1; n <= 6; n++) begin
         idle();
         checkOutput("blink_d0", seg[6:0], (n <= 4) ? 7'h40 : 7'h7F);
         checkOutput("blink_d1", seg[13:7], 7'h79);
      end
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 8'h05);
      idle();
      checkOutput("blink_rewrite", seg[6:0], 7'h40);
      for (int n = 0; n < 10; n++) idle();

      // Scan sequence from a fresh enable.
      applyStimulus(1'b0, 1'b1, 24'h00A5C3, 1'b1, 8'h00);
      idle();
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 8'h01);
      for (int n = 0; n < 14; n++) begin
         idle();
         checkOutput("scan_seq", dig_sel, scanExp[n]);
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         rr   = ($urandom_range(0, 59) == 0);
         rde  = ($urandom_range(0, 5) == 0);
         rce  = ($urandom_range(0, 9) == 0);
         rdat = 24'($urandom);
         if ($urandom_range(0, 1) == 0) rdat = rdat & 24'h000FFF;
         rc    = 8'($urandom);
         rc[0] = ($urandom_range(0, 3) != 0);
         applyStimulus(rr, rde, rdat, rce, rc);
      end

      // Reset beats a data write during active scanning.
      applyStimulus(1'b0, 1'b1, 24'h123456, 1'b1, 8'h01);
      for (int n = 0; n < 3; n++) idle();
      applyStimulus(1'b1, 1'b1, 24'hFFFFFF, 1'b0, 8'h00);
      checkOutput("rst_prio_rd_data", rd_data, 24'h0);
      checkOutput("rst_prio_seg", seg, allOff);
      checkOutput("rst_prio_mux", seg_mux, 7'h7F);
      checkOutput("rst_prio_sel", dig_sel, 6'h3F);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
